ps2_ascii_decoder: RTL and testbench
====================================

Name: ps2_ascii_decoder

Overview:
Converts the PS/2 scan-code byte stream from the keyboard receiver into buffered ASCII characters.
- Decodes make/break (F0) and extended (E0) prefixes.
- Tracks Shift and Caps Lock state and suppresses typematic repeats.
- Queues characters in a FIFO with a valid/ready interface toward the display/console logic.

Parameters:
FIFO_DEPTH, 8, number of ASCII entries buffered; power of two, >=2.
ALLOW_REPEAT, 0, 1 = every make of a held key emits a character; 0 = only the first make emits.
CAPS_AFFECTS_DIGITS, 0, 1 = Caps Lock also shifts digit keys; 0 = Caps Lock affects letters only.

Ports:
clk  input  1  system clock.
clrn  input  1  asynchronous active-low reset.
code_in  input  8  scan-code byte from the PS/2 receiver.
code_valid  input  1  one-cycle strobe; code_in is valid. Always accepted (no backpressure).
ascii_out  output  8  ASCII character at FIFO head.
ascii_valid  output  1  FIFO non-empty.
ascii_ready  input  1  consumer pops the head when ascii_valid && ascii_ready.
shift_active  output  1  left (12) or right (59) Shift held.
caps_lock  output  1  Caps Lock toggle state.
overflow  output  1  sticky; a character was dropped because the FIFO was full.

Behaviour:
- Reset (clrn low, async): FSM=IDLE, FIFO empty, ascii_valid=0, ascii_out=00, shift_active=0, caps_lock=0, overflow=0, held-key register=00. Reset mid-stream discards any partial prefix.
- Prefix FSM, advanced only on code_valid:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte = make(code), stay IDLE.
  - BRK: byte = break(code) -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte = extended make, ignored -> IDLE.
  - EXT_BRK: any byte = extended break, ignored -> IDLE.
  - E0 or F0 received in BRK/EXT/EXT_BRK: treat as a fresh prefix (BRK or EXT), never stall.
- Make handling:
  - 12 or 59: set the corresponding shift flag. shift_active = left | right.
  - 58: toggle caps_lock only if held-key != 58.
  - Other codes: if ALLOW_REPEAT=0 and code == held-key, no output. Otherwise translate and push if the translation is non-null. Then held-key <= code.
- Break handling:
  - 12 / 59: clear the matching shift flag.
  - Code == held-key: held-key <= 00.
  - No character is ever emitted on break.
- Translation (combinational):
  - Letters: 1C=A ... 1A=Z. Upper case (41-5A) when shift_active XOR caps_lock, else lower case (61-7A).
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46: unshifted '0'-'9' (30-39). Shifted ')!@#$%^&*(' (29,21,40,23,24,25,5E,26,2A,28).
  - Shift condition for digits: shift_active, XOR caps_lock only when CAPS_AFFECTS_DIGITS=1.
  - 29=20 (space), 5A=0D (enter), 66=08 (backspace); these are unaffected by modifiers.
  - All other codes map to null; null is never pushed.
- Latency: make byte on code_valid at cycle N -> entry written at edge N; ascii_valid=1 from cycle N+1 if the FIFO was empty (first-word fall-through, ascii_out registered from FIFO head).
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
  - Full when MSBs differ and the low bits are equal.
  - Push when full with no pop in the same cycle: character dropped, overflow <= 1 (cleared only by reset).
  - Simultaneous push and pop when full: both occur, no overflow.
  - Simultaneous push and pop when empty: push occurs, no pop (ascii_valid was 0).
- ascii_out holds its value while ascii_valid && !ascii_ready.
- Modifier state updates are independent of FIFO occupancy.

Test Plan:
1. Reset, then bytes 1C, F0, 1C -> exactly one entry 61 ('a'), ascii_valid rises one cycle after the 1C strobe; shift_active=0.
2. 12, 1C, F0 1C, F0 12, 58, F0 58, 32 -> outputs 41 ('A'), then 42 ('B') via Caps Lock; caps_lock=1 after 58; shift_active toggles 1->0.
3. 12, 16, F0 16, F0 12 with CAPS_AFFECTS_DIGITS=0 and caps_lock=1 -> single 21 ('!'); then 16 alone -> 31.
4. Held key 1D repeated five times, then F0 1D -> ALLOW_REPEAT=0: one 77 ('w'); ALLOW_REPEAT=1: five 77s.
5. ascii_ready=0, FIFO_DEPTH+2 distinct letter makes -> ascii_valid=1, the first FIFO_DEPTH chars are retained in order, overflow=1; drain -> exact order, ascii_valid=0 after the last pop, overflow stays 1.
6. E0 75, E0 F0 75 (arrow key), then clrn pulsed low after a lone F0, then 1C -> no output from the arrow; after reset, 1C emits 61 (the prefix was discarded).

Source files
------------

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with make/break/extended prefix
// tracking, Shift/Caps Lock state, typematic repeat suppression and an output FIFO.
module ps2_ascii_decoder #(
    parameter int unsigned FIFO_DEPTH          = 8,
    parameter int unsigned ALLOW_REPEAT        = 0,
    parameter int unsigned CAPS_AFFECTS_DIGITS = 0
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       shift_active,
    output logic       caps_lock,
    output logic       overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_CAPS    = 8'h58;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        is_make, is_break;
    logic        shift_l, shift_r;
    logic [7:0]  held;

    logic        letter_hit, digit_hit;
    logic [4:0]  letter_idx;
    logic [3:0]  digit_idx;
    logic [7:0]  digit_shifted;
    logic        letter_upper, digit_upper;
    logic [7:0]  xlat;
    logic        repeat_blocked, push_req, do_push, pop;

    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        empty, full;

    assign shift_active = shift_l | shift_r;

    // Prefix FSM: F0/E0 always restart a prefix so a corrupted stream never stalls.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        is_make   = 1'b0;
        is_break  = 1'b0;
        if (code_valid) begin
            if (code_in == SC_EXT) begin
                state_nxt = EXT;
            end else if (code_in == SC_BREAK) begin
                state_nxt = (state == EXT) ? EXT_BRK : BRK;
            end else begin
                state_nxt = IDLE;
                case (state)
                    IDLE:    is_make  = 1'b1;
                    BRK:     is_break = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        letter_hit = 1'b1;
        letter_idx = 5'd0;
        case (code_in)
            8'h1C: letter_idx = 5'd0;
            8'h32: letter_idx = 5'd1;
            8'h21: letter_idx = 5'd2;
            8'h23: letter_idx = 5'd3;
            8'h24: letter_idx = 5'd4;
            8'h2B: letter_idx = 5'd5;
            8'h34: letter_idx = 5'd6;
            8'h33: letter_idx = 5'd7;
            8'h43: letter_idx = 5'd8;
            8'h3B: letter_idx = 5'd9;
            8'h42: letter_idx = 5'd10;
            8'h4B: letter_idx = 5'd11;
            8'h3A: letter_idx = 5'd12;
            8'h31: letter_idx = 5'd13;
            8'h44: letter_idx = 5'd14;
            8'h4D: letter_idx = 5'd15;
            8'h15: letter_idx = 5'd16;
            8'h2D: letter_idx = 5'd17;
            8'h1B: letter_idx = 5'd18;
            8'h2C: letter_idx = 5'd19;
            8'h3C: letter_idx = 5'd20;
            8'h2A: letter_idx = 5'd21;
            8'h1D: letter_idx = 5'd22;
            8'h22: letter_idx = 5'd23;
            8'h35: letter_idx = 5'd24;
            8'h1A: letter_idx = 5'd25;
            default: letter_hit = 1'b0;
        endcase
    end

    always_comb begin
        digit_hit = 1'b1;
        digit_idx = 4'd0;
        case (code_in)
            8'h45: digit_idx = 4'd0;
            8'h16: digit_idx = 4'd1;
            8'h1E: digit_idx = 4'd2;
            8'h26: digit_idx = 4'd3;
            8'h25: digit_idx = 4'd4;
            8'h2E: digit_idx = 4'd5;
            8'h36: digit_idx = 4'd6;
            8'h3D: digit_idx = 4'd7;
            8'h3E: digit_idx = 4'd8;
            8'h46: digit_idx = 4'd9;
            default: digit_hit = 1'b0;
        endcase
    end

    always_comb begin
        digit_shifted = 8'h00;
        case (digit_idx)
            4'd0:    digit_shifted = 8'h29;
            4'd1:    digit_shifted = 8'h21;
            4'd2:    digit_shifted = 8'h40;
            4'd3:    digit_shifted = 8'h23;
            4'd4:    digit_shifted = 8'h24;
            4'd5:    digit_shifted = 8'h25;
            4'd6:    digit_shifted = 8'h5E;
            4'd7:    digit_shifted = 8'h26;
            4'd8:    digit_shifted = 8'h2A;
            4'd9:    digit_shifted = 8'h28;
            default: digit_shifted = 8'h00;
        endcase
    end

    assign letter_upper = shift_active ^ caps_lock;
    assign digit_upper  = (CAPS_AFFECTS_DIGITS != 0) ? (shift_active ^ caps_lock) : shift_active;

    // A zero translation means "no character"; it is never pushed.
    always_comb begin
        xlat = 8'h00;
        if (letter_hit) begin
            xlat = (letter_upper ? 8'h41 : 8'h61) + {3'b000, letter_idx};
        end else if (digit_hit) begin
            xlat = digit_upper ? digit_shifted : (8'h30 + {4'b0000, digit_idx});
        end else begin
            case (code_in)
                8'h29:   xlat = 8'h20;
                8'h5A:   xlat = 8'h0D;
                8'h66:   xlat = 8'h08;
                default: xlat = 8'h00;
            endcase
        end
    end

    // Modifiers and the held key; Caps Lock only toggles on its first make.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_lock <= 1'b0;
            held      <= 8'h00;
        end else if (is_make) begin
            case (code_in)
                SC_LSHIFT: shift_l <= 1'b1;
                SC_RSHIFT: shift_r <= 1'b1;
                SC_CAPS: begin
                    if (held != SC_CAPS) caps_lock <= ~caps_lock;
                    held <= SC_CAPS;
                end
                default: held <= code_in;
            endcase
        end else if (is_break) begin
            if (code_in == SC_LSHIFT) shift_l <= 1'b0;
            if (code_in == SC_RSHIFT) shift_r <= 1'b0;
            if (code_in == held)      held    <= 8'h00;
        end
    end

    assign repeat_blocked = (ALLOW_REPEAT == 0) && (code_in == held);
    assign push_req       = is_make && !repeat_blocked && (xlat != 8'h00);

    // FIFO; valid/ready: a transfer happens on a clock edge where ascii_valid && ascii_ready,
    // ascii_out is stable while ascii_valid is high and ascii_ready is low.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ascii_valid = !empty;
    assign ascii_out   = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign pop         = ascii_valid && ascii_ready;
    assign do_push     = push_req && (!full || pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= xlat;
    end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Randomized and directed bench for ps2_ascii_decoder against a keyboard-level
// reference model; a scoreboard queue holds the expected ASCII stream.
module tb_ps2_ascii_decoder;

    localparam int DEPTH        = 8;
    localparam int ALLOW_REPEAT = 0;
    localparam int CAPS_DIGITS  = 0;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic       ascii_ready = 1'b0;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       shift_active;
    logic       caps_lock;
    logic       overflow;

    ps2_ascii_decoder #(
        .FIFO_DEPTH(DEPTH),
        .ALLOW_REPEAT(ALLOW_REPEAT),
        .CAPS_AFFECTS_DIGITS(CAPS_DIGITS)
    ) dut (
        .clk(clk),
        .clrn(clrn),
        .code_in(code_in),
        .code_valid(code_valid),
        .ascii_out(ascii_out),
        .ascii_valid(ascii_valid),
        .ascii_ready(ascii_ready),
        .shift_active(shift_active),
        .caps_lock(caps_lock),
        .overflow(overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] exp_q[$];
    int         model_count;
    bit         m_shl, m_shr, m_caps, m_ovf, m_brk, m_ext;
    logic [7:0] m_held;

    logic [7:0] letter_scan [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
    logic [7:0] digit_scan [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
    logic [7:0] digit_sym  [10] = '{")", "!", "@", "#", "$", "%", "^", "&", "*", "("};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_char(input logic [7:0] c);
        bit sh;
        bit dsh;
        sh  = m_shl | m_shr;
        dsh = (CAPS_DIGITS != 0) ? (sh ^ m_caps) : sh;
        for (int i = 0; i < 26; i++)
            if (letter_scan[i] == c) return ((sh ^ m_caps) ? "A" : "a") + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digit_scan[i] == c) return dsh ? digit_sym[i] : "0" + 8'(i);
        if (c == 8'h29) return " ";
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        model_count = 0;
        {m_shl, m_shr, m_caps, m_ovf, m_brk, m_ext} = '0;
        m_held = 8'h00;
    endtask

    // one keypress/release event as a keyboard sees it; push_ok says whether a slot frees this edge
    task automatic model_byte(input logic [7:0] c, input bit pop);
        logic [7:0] ch;
        if (c == 8'hF0) begin
            if (!(m_ext && !m_brk)) m_ext = 0;
            m_brk = 1;
        end else if (c == 8'hE0) begin
            m_ext = 1;
            m_brk = 0;
        end else begin
            if (!m_ext && !m_brk) begin
                ch = ref_char(c);
                if (c == 8'h12) m_shl = 1;
                else if (c == 8'h59) m_shr = 1;
                else if (c == 8'h58) begin
                    if (m_held != 8'h58) m_caps = !m_caps;
                    m_held = 8'h58;
                end else begin
                    if (!(ALLOW_REPEAT == 0 && c == m_held) && ch != 8'h00) begin
                        if (model_count < DEPTH || pop) begin
                            exp_q.push_back(ch);
                            model_count++;
                        end else m_ovf = 1;
                    end
                    m_held = c;
                end
            end else if (m_brk && !m_ext) begin
                if (c == 8'h12) m_shl = 0;
                if (c == 8'h59) m_shr = 0;
                if (c == m_held) m_held = 8'h00;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // driver: inputs change 1 time unit after the rising edge, model updates at the edge
    task automatic step(input bit v, input logic [7:0] c, input bit rdy);
        bit pop;
        code_valid  = v;
        code_in     = c;
        ascii_ready = rdy;
        @(posedge clk);
        pop = rdy && (model_count > 0);
        if (v) model_byte(c, pop);
        if (pop) model_count--;
        #1;
        code_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        step(1'b1, c, 1'b1);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
    endtask

    task automatic do_reset();
        clrn       = 1'b0;
        code_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {7'b0, ascii_valid}, 8'h00);
        chk("rst_out", ascii_out, 8'h00);
        chk("rst_shift", {7'b0, shift_active}, 8'h00);
        chk("rst_caps", {7'b0, caps_lock}, 8'h00);
        chk("rst_ovf", {7'b0, overflow}, 8'h00);
        clrn = 1'b1;
    endtask

    // monitor: compares state every cycle, pops the scoreboard on each transfer
    always @(negedge clk) begin
        if (clrn) begin
            chk("ascii_valid", {7'b0, ascii_valid}, {7'b0, model_count > 0});
            chk("shift_active", {7'b0, shift_active}, {7'b0, m_shl | m_shr});
            chk("caps_lock", {7'b0, caps_lock}, {7'b0, m_caps});
            chk("overflow", {7'b0, overflow}, {7'b0, m_ovf});
            if (ascii_valid && ascii_ready) begin
                if (exp_q.size() == 0) chk("unexpected_char", ascii_out, 8'h00);
                else chk("ascii_out", ascii_out, exp_q.pop_front());
            end
        end
    end

    logic [7:0] pick;
    logic [7:0] specials [6] = '{8'h29, 8'h5A, 8'h66, 8'h12, 8'h59, 8'h58};

    initial begin
        model_reset();
        do_reset();
        @(posedge clk);
        #1;

        // 1: plain letter, ready held low briefly so valid latency is visible
        step(1'b1, 8'h1C, 1'b0);
        idle(2, 1'b0);
        send(8'hF0); send(8'h1C);
        idle(2, 1'b1);

        // 2: shifted letter, then Caps Lock
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58); send(8'h32);
        send(8'hF0); send(8'h32);
        idle(2, 1'b1);
        chk("t2_caps", {7'b0, caps_lock}, 8'h01);

        // 3: digits under caps lock
        send(8'h12); send(8'h16); send(8'hF0); send(8'h16); send(8'hF0); send(8'h12);
        send(8'h16); send(8'hF0); send(8'h16);
        idle(2, 1'b1);

        // 4: typematic repeat of a held key
        for (int i = 0; i < 5; i++) send(8'h1D);
        send(8'hF0); send(8'h1D);
        idle(2, 1'b1);

        // 5: overflow with the consumer stalled, then drain
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, letter_scan[i], 1'b0);
        idle(1, 1'b0);
        chk("t5_ovf", {7'b0, overflow}, 8'h01);
        chk("t5_fill", 8'(exp_q.size()), 8'(DEPTH));
        idle(DEPTH + 2, 1'b1);
        chk("t5_drained", 8'(exp_q.size()), 8'h00);

        // 6: extended key ignored, reset drops a partial prefix
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        idle(2, 1'b1);
        send(8'hF0);
        do_reset();
        @(posedge clk);
        #1;
        send(8'h1C);
        idle(2, 1'b1);
        chk("t6_after_rst", 8'(exp_q.size()), 8'h00);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: pick = letter_scan[$urandom_range(0, 25)];
                4:          pick = digit_scan[$urandom_range(0, 9)];
                5:          pick = 8'hF0;
                6:          pick = 8'hE0;
                7, 8:       pick = specials[$urandom_range(0, 5)];
                default:    pick = 8'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 2) != 0, pick, $urandom_range(0, 3) != 0);
        end
        idle(DEPTH + 4, 1'b1);
        chk("final_empty", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
